irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Multi-channel interrupt controller between external interrupt pins and the program sequencer (PS).
//  Replaces the single raw interrupt pin into the core with synchronised, maskable, prioritised channels.
//  Supports per-channel edge/level mode and nested service.
//  Hands one vectored request at a time to the PS through a req/ack handshake.
// PARAMETERS
//  NUM_IRQ     8         number of interrupt channels; channel 0 = highest priority
//  PMA_SIZE    16        program-memory address width of the vector
//  VEC_BASE    16'h0100  PM address of channel-0 service routine
//  VEC_SHIFT   2         vector = VEC_BASE + (id << VEC_SHIFT)
// PORTS
//  clk            in   1                 core clock
//  reset          in   1                 asynchronous, active-low reset
//  irq_in         in   NUM_IRQ           asynchronous interrupt pins
//  ps_ic_gie      in   1                 global interrupt enable from PS
//  ps_ic_wr_en    in   1                 register write strobe
//  ps_ic_wr_sel   in   2                 0=IMASK, 1=IMODE (1=edge), 2=ILAT clear (write-1-to-clear), 3=reserved/ignored
//  ps_ic_wr_dt    in   NUM_IRQ           write data
//  ps_ic_ack      in   1                 PS has taken the vector (ISR entry)
//  ps_ic_rti      in   1                 return-from-interrupt executed
//  ic_ps_req      out  1                 vectored request pending
//  ic_ps_vec      out  PMA_SIZE          service-routine address
//  ic_ps_id       out  $clog2(NUM_IRQ)   channel being requested
//  ic_ps_imask    out  NUM_IRQ           IMASK readback
//  ic_ps_ilat     out  NUM_IRQ           latch readback
//  ic_ps_isr      out  NUM_IRQ           in-service readback
// BEHAVIOUR
//  - Reset (reset=0, async): IMASK/IMODE/ILAT/ISR = 0, sync flops = 0, FSM=IDLE; ic_ps_req=0, ic_ps_vec=VEC_BASE, ic_ps_id=0.
//  - irq_in passes a 2-flop synchroniser per channel; edge detect uses a third flop.
//  - Edge mode: rising edge of synced input sets ILAT[i]. Level mode: ILAT[i] set every cycle synced input is high.
//  - ILAT clear by write-1: ignored for a bit being set the same cycle (set wins).
//  - Latency: irq_in high at edge N -> ILAT set at edge N+2 -> ic_ps_req high after edge N+3 (if eligible).
//  - Eligible = ILAT & IMASK, gated by ps_ic_gie.
//  - Winner = lowest eligible index, and only if its index < lowest set ISR bit (strict preemption; equal/lower never nests).
//  - FSM IDLE: winner exists -> REQ; capture id; vec=VEC_BASE+(id<<VEC_SHIFT); req=1.
//  - FSM REQ: id/vec frozen while req=1, even if a higher-priority channel latches meanwhile.
//  - FSM REQ + ps_ic_ack: ILAT[id] cleared (edge mode only; level re-latches while pin high); ISR[id] set; req=0; -> IDLE.
//  - FSM REQ withdraw: ILAT[id] or IMASK[id] or gie drops before ack (no ack same cycle) -> req=0 next edge, -> IDLE, no ISR change.
//  - Ack and withdraw in same cycle: ack wins.
//  - Re-arbitration: one IDLE cycle minimum between successive requests.
//  - ps_ic_rti: clears lowest-index set ISR bit; ignored if ISR=0. rti+ack same cycle: rti clears first, then ack sets ISR[id].
//  - Spurious/ignored events: ps_ic_ack in IDLE ignored.
//  - Register writes take effect at next edge; IMODE change does not clear ILAT.
//  - Vector arithmetic modulo 2^PMA_SIZE.
// STRUCTURE
//  - ic_pkg: write-select codes (IC_SEL_IMASK/IMODE/ILAT), FSM state enum {IC_IDLE, IC_REQ}, id width function.
//  - Sub-module ic_prio_enc: parametrised lowest-index-first priority encoder (valid + index).
//    Used twice: eligible vector, and ISR for current service level.
//  - Top holds synchroniser, registers, FSM, vector adder.
// TESTING
//  1. Reset mid-REQ: assert reset=0 while req=1 -> req=0, vec=16'h0100, all registers 0 immediately (async).
//  2. Edge ch3, IMASK=8'h08, IMODE=8'h08, gie=1: pulse irq_in[3] at edge N -> req at N+3, id=3, vec=16'h010C.
//     After ack -> ILAT=0, ISR=8'h08.
//  3. Nesting: ISR=8'h08; latch ch5 -> no req. Latch ch1 -> req id=1, vec=16'h0104; ack -> ISR=8'h0A.
//     rti -> ISR=8'h08; rti -> ISR=0, then ch5 requested.
//  4. Freeze/withdraw: req id=4 pending, then ch0 latches -> id stays 4. Clear IMASK[4] -> req drops next edge, then id=0 requested.
//  5. Level mode ch2: hold irq_in[2] high, ack -> ILAT[2] re-sets; W1C clear while pin high -> ILAT[2] stays 1.
//     Drop pin, clear -> ILAT=0.
//  6. Simultaneous ack+rti with ISR=8'h10, req id=1 -> ISR=8'h02.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared definitions for the interrupt controller: register-write select codes,
// controller FSM states and the channel-id width helper.
package ic_pkg;

  localparam logic [1:0] IC_SEL_IMASK = 2'd0;
  localparam logic [1:0] IC_SEL_IMODE = 2'd1;
  localparam logic [1:0] IC_SEL_ILAT  = 2'd2;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_REQ  = 1'b1
  } ic_state_e;

  // A single channel still needs a one-bit id field.
  function automatic int ic_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ic_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any bit is set and the
// index of the lowest set bit.
module ic_prio_enc
  import ic_pkg::*;
#(
  parameter int N = 8,
  parameter int W = ic_id_w(N)
) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [W-1:0] idx
);

  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Multi-channel interrupt controller: synchronises pins, latches edge/level events,
// arbitrates by fixed priority with strict nesting, and hands vectors to the PS.
module irq_ctrl
  import ic_pkg::*;
#(
  parameter int                  NUM_IRQ   = 8,
  parameter int                  PMA_SIZE  = 16,
  parameter logic [PMA_SIZE-1:0] VEC_BASE  = PMA_SIZE'(16'h0100),
  parameter int                  VEC_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IRQ-1:0]           irq_in,
  input  logic                         ps_ic_gie,
  input  logic                         ps_ic_wr_en,
  input  logic [1:0]                   ps_ic_wr_sel,
  input  logic [NUM_IRQ-1:0]           ps_ic_wr_dt,
  input  logic                         ps_ic_ack,
  input  logic                         ps_ic_rti,
  output logic                         ic_ps_req,
  output logic [PMA_SIZE-1:0]          ic_ps_vec,
  output logic [ic_id_w(NUM_IRQ)-1:0]  ic_ps_id,
  output logic [NUM_IRQ-1:0]           ic_ps_imask,
  output logic [NUM_IRQ-1:0]           ic_ps_ilat,
  output logic [NUM_IRQ-1:0]           ic_ps_isr
);

  localparam int ID_W = ic_id_w(NUM_IRQ);

  logic [NUM_IRQ-1:0] sync_p0, sync_p1, sync_p2;
  logic [NUM_IRQ-1:0] imask, imode, ilat, isr;
  ic_state_e          state;

  logic [NUM_IRQ-1:0] lat_set, elig, id_onehot;
  logic [NUM_IRQ-1:0] wr_clr, ack_clr, rti_clr, ack_set;
  logic [NUM_IRQ-1:0] ilat_nxt, isr_nxt;
  logic               win_vld, isr_vld, win_go, cur_live, ack_take, withdraw;
  logic [ID_W-1:0]    win_idx, isr_idx;
  logic [PMA_SIZE-1:0] win_vec;

  // Stage p0/p1: two-flop synchroniser; stage p2: previous synced value for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= irq_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Edge channels latch on a rising synced input, level channels every high cycle.
  assign lat_set = (imode & sync_p1 & ~sync_p2) | (~imode & sync_p1);

  assign elig = ilat & imask & {NUM_IRQ{ps_ic_gie}};

  ic_prio_enc #(.N(NUM_IRQ), .W(ID_W)) u_elig_enc (
    .req (elig),
    .vld (win_vld),
    .idx (win_idx)
  );

  ic_prio_enc #(.N(NUM_IRQ), .W(ID_W)) u_isr_enc (
    .req (isr),
    .vld (isr_vld),
    .idx (isr_idx)
  );

  // Only a strictly higher priority than the current service level may nest.
  assign win_go  = win_vld && (!isr_vld || (win_idx < isr_idx));
  assign win_vec = VEC_BASE + (PMA_SIZE'(win_idx) << VEC_SHIFT);

  assign id_onehot = NUM_IRQ'(1) << ic_ps_id;
  assign cur_live  = |(elig & id_onehot);
  assign ack_take  = (state == IC_REQ) && ps_ic_ack;
  assign withdraw  = (state == IC_REQ) && !ps_ic_ack && !cur_live;

  assign wr_clr  = (ps_ic_wr_en && (ps_ic_wr_sel == IC_SEL_ILAT)) ? ps_ic_wr_dt : '0;
  assign ack_clr = ack_take ? (id_onehot & imode) : '0;
  assign rti_clr = (ps_ic_rti && isr_vld) ? (NUM_IRQ'(1) << isr_idx) : '0;
  assign ack_set = ack_take ? id_onehot : '0;

  // A new event in the same cycle beats any clear; rti retires before ack enters.
  assign ilat_nxt = (ilat & ~(wr_clr | ack_clr)) | lat_set;
  assign isr_nxt  = (isr & ~rti_clr) | ack_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imask <= '0;
      imode <= '0;
      ilat  <= '0;
      isr   <= '0;
    end else begin
      ilat <= ilat_nxt;
      isr  <= isr_nxt;
      if (ps_ic_wr_en && (ps_ic_wr_sel == IC_SEL_IMASK)) imask <= ps_ic_wr_dt;
      if (ps_ic_wr_en && (ps_ic_wr_sel == IC_SEL_IMODE)) imode <= ps_ic_wr_dt;
    end
  end

  // Request FSM: id/vec are captured on entry to REQ and held until ack or withdraw.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IC_IDLE;
      ic_ps_req <= 1'b0;
      ic_ps_id  <= '0;
      ic_ps_vec <= VEC_BASE;
    end else begin
      unique case (state)
        IC_IDLE: begin
          if (win_go) begin
            state     <= IC_REQ;
            ic_ps_req <= 1'b1;
            ic_ps_id  <= win_idx;
            ic_ps_vec <= win_vec;
          end
        end
        IC_REQ: begin
          if (ack_take || withdraw) begin
            state     <= IC_IDLE;
            ic_ps_req <= 1'b0;
          end
        end
        default: begin
          state     <= IC_IDLE;
          ic_ps_req <= 1'b0;
        end
      endcase
    end
  end

  assign ic_ps_imask = imask;
  assign ic_ps_ilat  = ilat;
  assign ic_ps_isr   = isr;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a behavioural model of the controller.
module tb_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_in;
  logic        ps_ic_gie;
  logic        ps_ic_wr_en;
  logic [1:0]  ps_ic_wr_sel;
  logic [7:0]  ps_ic_wr_dt;
  logic        ps_ic_ack;
  logic        ps_ic_rti;
  logic        ic_ps_req;
  logic [15:0] ic_ps_vec;
  logic [2:0]  ic_ps_id;
  logic [7:0]  ic_ps_imask;
  logic [7:0]  ic_ps_ilat;
  logic [7:0]  ic_ps_isr;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  irq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .ps_ic_gie    (ps_ic_gie),
    .ps_ic_wr_en  (ps_ic_wr_en),
    .ps_ic_wr_sel (ps_ic_wr_sel),
    .ps_ic_wr_dt  (ps_ic_wr_dt),
    .ps_ic_ack    (ps_ic_ack),
    .ps_ic_rti    (ps_ic_rti),
    .ic_ps_req    (ic_ps_req),
    .ic_ps_vec    (ic_ps_vec),
    .ic_ps_id     (ic_ps_id),
    .ic_ps_imask  (ic_ps_imask),
    .ic_ps_ilat   (ic_ps_ilat),
    .ic_ps_isr    (ic_ps_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pin history, architectural registers and the pending request.
  typedef struct packed {
    logic [7:0]  smp0, smp1, smp2;
    logic [7:0]  imask, imode, ilat, isr;
    logic        req;
    logic [2:0]  id;
    logic [15:0] vec;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t r;
    r = '0;
    r.vec = 16'h0100;
    return r;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic [7:0] pins, logic gie, logic wr_en,
                                         logic [1:0] sel, logic [7:0] dt, logic ack, logic rti);
    mstate_t n;
    logic [7:0] live, setv, clrv;
    int w, lo;
    logic take;
    n = s;
    live = gie ? (s.ilat & s.imask) : 8'h00;
    w = -1;
    for (int i = 0; i < 8; i++) if (live[i] && w < 0) w = i;
    lo = 8;
    for (int i = 0; i < 8; i++) if (s.isr[i] && lo == 8) lo = i;
    take = 1'b0;
    if (!s.req) begin
      if (w >= 0 && w < lo) begin
        n.req = 1'b1;
        n.id  = 3'(w);
        n.vec = 16'(32'h0100 + w * 4);
      end
    end else if (ack) begin
      take  = 1'b1;
      n.req = 1'b0;
    end else if (!live[s.id]) begin
      n.req = 1'b0;
    end
    for (int i = 0; i < 8; i++)
      setv[i] = s.imode[i] ? (s.smp1[i] && !s.smp2[i]) : s.smp1[i];
    clrv = (wr_en && sel == 2'd2) ? dt : 8'h00;
    if (take && s.imode[s.id]) clrv[s.id] = 1'b1;
    n.ilat = (s.ilat & ~clrv) | setv;
    if (rti && lo < 8) n.isr[lo] = 1'b0;
    if (take) n.isr[s.id] = 1'b1;
    if (wr_en && sel == 2'd0) n.imask = dt;
    if (wr_en && sel == 2'd1) n.imode = dt;
    n.smp2 = s.smp1;
    n.smp1 = s.smp0;
    n.smp0 = pins;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else m <= model_next(m, irq_in, ps_ic_gie, ps_ic_wr_en, ps_ic_wr_sel, ps_ic_wr_dt,
                         ps_ic_ack, ps_ic_rti);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", 32'(ic_ps_req), 32'(m.req));
      if (m.req) begin
        chk("id", 32'(ic_ps_id), 32'(m.id));
        chk("vec", 32'(ic_ps_vec), 32'(m.vec));
      end
      chk("imask", 32'(ic_ps_imask), 32'(m.imask));
      chk("ilat", 32'(ic_ps_ilat), 32'(m.ilat));
      chk("isr", 32'(ic_ps_isr), 32'(m.isr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] dt);
    ps_ic_wr_en = 1'b1; ps_ic_wr_sel = sel; ps_ic_wr_dt = dt;
    tick();
    ps_ic_wr_en = 1'b0;
  endtask

  task automatic pulse(input int ch);
    irq_in[ch] = 1'b1;
    tick();
    irq_in[ch] = 1'b0;
  endtask

  task automatic do_ack(input logic with_rti);
    ps_ic_ack = 1'b1; ps_ic_rti = with_rti;
    tick();
    ps_ic_ack = 1'b0; ps_ic_rti = 1'b0;
  endtask

  task automatic do_rti();
    ps_ic_rti = 1'b1;
    tick();
    ps_ic_rti = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; ps_ic_gie = 1'b1; ps_ic_wr_en = 1'b0;
    ps_ic_wr_sel = '0; ps_ic_wr_dt = '0; ps_ic_ack = 1'b0; ps_ic_rti = 1'b0;
    tick(3);
    chk("rst_req", 32'(ic_ps_req), 0);
    chk("rst_vec", 32'(ic_ps_vec), 32'h0100);
    chk("rst_id", 32'(ic_ps_id), 0);
    reset = 1'b1;
    chk_en = 1'b1;
    tick();

    // Edge channel 3: three-edge latency to request, ack moves it into service.
    wr(2'd0, 8'h08);
    wr(2'd1, 8'h08);
    pulse(3);
    tick(2);
    chk("t2_req_early", 32'(ic_ps_req), 0);
    chk("t2_ilat", 32'(ic_ps_ilat), 32'h08);
    tick();
    chk("t2_req", 32'(ic_ps_req), 1);
    chk("t2_id", 32'(ic_ps_id), 3);
    chk("t2_vec", 32'(ic_ps_vec), 32'h010C);
    do_ack(1'b0);
    chk("t2_ilat_ack", 32'(ic_ps_ilat), 0);
    chk("t2_isr", 32'(ic_ps_isr), 32'h08);

    // Nesting under ch3 in service.
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h2A);
    pulse(5);
    tick(4);
    chk("t3_no_req", 32'(ic_ps_req), 0);
    chk("t3_ilat5", 32'(ic_ps_ilat), 32'h20);
    pulse(1);
    tick(3);
    chk("t3_req1", 32'(ic_ps_req), 1);
    chk("t3_id1", 32'(ic_ps_id), 1);
    chk("t3_vec1", 32'(ic_ps_vec), 32'h0104);
    do_ack(1'b0);
    chk("t3_isr_0a", 32'(ic_ps_isr), 32'h0A);
    do_rti();
    chk("t3_isr_08", 32'(ic_ps_isr), 32'h08);
    tick();
    chk("t3_still_blocked", 32'(ic_ps_req), 0);
    do_rti();
    chk("t3_isr_00", 32'(ic_ps_isr), 0);
    tick();
    chk("t3_req5", 32'(ic_ps_req), 1);
    chk("t3_id5", 32'(ic_ps_id), 5);
    chk("t3_vec5", 32'(ic_ps_vec), 32'h0114);
    do_ack(1'b0);
    do_rti();

    // Frozen id while a higher channel latches, then withdraw by masking.
    wr(2'd0, 8'h11);
    pulse(4);
    tick(3);
    chk("t4_id4", 32'(ic_ps_id), 4);
    pulse(0);
    tick(3);
    chk("t4_frozen_req", 32'(ic_ps_req), 1);
    chk("t4_frozen_id", 32'(ic_ps_id), 4);
    wr(2'd0, 8'h01);
    chk("t4_req_hold", 32'(ic_ps_req), 1);
    tick();
    chk("t4_withdrawn", 32'(ic_ps_req), 0);
    chk("t4_isr_same", 32'(ic_ps_isr), 0);
    tick();
    chk("t4_req0", 32'(ic_ps_req), 1);
    chk("t4_id0", 32'(ic_ps_id), 0);
    chk("t4_vec0", 32'(ic_ps_vec), 32'h0100);
    do_ack(1'b0);
    do_rti();
    wr(2'd2, 8'hFF);
    chk("t4_ilat_clr", 32'(ic_ps_ilat), 0);

    // Level channel 2 re-latches while the pin is held.
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h04);
    irq_in[2] = 1'b1;
    tick(4);
    chk("t5_req", 32'(ic_ps_req), 1);
    chk("t5_vec", 32'(ic_ps_vec), 32'h0108);
    do_ack(1'b0);
    chk("t5_ilat_relatch", 32'(ic_ps_ilat), 32'h04);
    chk("t5_isr", 32'(ic_ps_isr), 32'h04);
    wr(2'd2, 8'h04);
    chk("t5_set_wins", 32'(ic_ps_ilat), 32'h04);
    irq_in[2] = 1'b0;
    tick(3);
    wr(2'd2, 8'h04);
    chk("t5_ilat_zero", 32'(ic_ps_ilat), 0);
    do_rti();

    // Ack and rti together: rti retires ch4, ack enters ch1.
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h12);
    pulse(4);
    tick(3);
    do_ack(1'b0);
    chk("t6_isr10", 32'(ic_ps_isr), 32'h10);
    pulse(1);
    tick(3);
    chk("t6_id1", 32'(ic_ps_id), 1);
    do_ack(1'b1);
    chk("t6_isr02", 32'(ic_ps_isr), 32'h02);
    do_rti();

    // Asynchronous reset while a request is pending.
    wr(2'd0, 8'h80);
    pulse(7);
    tick(3);
    chk("t1_req_before", 32'(ic_ps_req), 1);
    chk("t1_vec_before", 32'(ic_ps_vec), 32'h011C);
    #3 reset = 1'b0;
    #1;
    chk("t1_req", 32'(ic_ps_req), 0);
    chk("t1_vec", 32'(ic_ps_vec), 32'h0100);
    chk("t1_id", 32'(ic_ps_id), 0);
    chk("t1_imask", 32'(ic_ps_imask), 0);
    chk("t1_ilat", 32'(ic_ps_ilat), 0);
    chk("t1_isr", 32'(ic_ps_isr), 0);
    tick();
    reset = 1'b1;
    tick();

    // Random traffic against the model.
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'($urandom));
    for (int c = 0; c < 3000; c++) begin
      irq_in       = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ps_ic_gie    = ($urandom % 20) != 0;
      ps_ic_wr_en  = ($urandom % 16) == 0;
      ps_ic_wr_sel = 2'($urandom);
      ps_ic_wr_dt  = 8'($urandom);
      ps_ic_ack    = ic_ps_req ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      ps_ic_rti    = ($urandom % 10) == 0;
      tick();
    end
    irq_in = '0; ps_ic_wr_en = 1'b0; ps_ic_ack = 1'b0; ps_ic_rti = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
